interval_timer: RTL and testbench

INTERVAL_TIMER -- requirements
Module: interval_timer

---
 rtl/interval_timer.sv | 107 ++++++++++
 tb/tb_interval_timer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/interval_timer.sv
// Interval timer: loads a 4-bit second count and counts it down using a CLK_DIV prescaler.
// Pulses one_hz on every second tick and expired when the interval runs out.
module interval_timer #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       start_timer,
  input  logic       clear,
  input  logic [3:0] value,
  output logic       expired,
  output logic       busy,
  output logic [3:0] remaining,
  output logic       one_hz
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COUNT} state_t;

  state_t        state, state_next;
  logic [PW-1:0] pre, pre_next;
  logic [3:0]    rem_next;
  logic          exp_next, hz_next;
  logic          tick;

  assign tick = (state == COUNT) && (pre == PRE_MAX);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
    state_next = state;
    pre_next   = pre;
    rem_next   = remaining;
    exp_next   = 1'b0;
    hz_next    = 1'b0;

    case (state)
      IDLE: begin
        pre_next = '0;
        if (start_timer) state_next = LOAD;
      end
      LOAD: begin
        pre_next = '0;
        // A repeated start keeps us in LOAD; value is taken only on the cycle we leave.
        if (!start_timer) begin
          rem_next = value;
          if (value == 4'd0) begin
            exp_next   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = COUNT;
          end
        end
      end
      COUNT: begin
        if (tick) begin
          pre_next = '0;
          hz_next  = 1'b1;
          if (remaining <= 4'd1) begin
            rem_next   = 4'd0;
            exp_next   = 1'b1;
            state_next = IDLE;
          end else begin
            rem_next = remaining - 4'd1;
          end
        end else begin
          pre_next = pre + 1'b1;
        end
        // Retrigger wins the next state, but a coincident expiry still pulses.
        if (start_timer) begin
          state_next = LOAD;
          pre_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase

    if (clear) begin
      state_next = IDLE;
      pre_next   = '0;
      rem_next   = 4'd0;
      exp_next   = 1'b0;
      hz_next    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (!Reset_n) begin
      state     <= IDLE;
      pre       <= '0;
      remaining <= 4'd0;
      expired   <= 1'b0;
      busy      <= 1'b0;
      one_hz    <= 1'b0;
    end else begin
      state     <= state_next;
      pre       <= pre_next;
      remaining <= rem_next;
      expired   <= exp_next;
      busy      <= (state_next != IDLE);
      one_hz    <= hz_next;
    end
  end

endmodule

// File: tb/tb_interval_timer.sv
// Scoreboard bench for interval_timer: a time-based reference model queues expected outputs
// per edge; a monitor pops and compares them on the falling edge.
module tb_interval_timer;

  localparam int CLK_DIV = 4;

  typedef struct packed {
    logic       expired;
    logic       busy;
    logic [3:0] remaining;
    logic       one_hz;
  } out_t;

  logic       clk;
  logic       rst_n;
  logic       start_timer;
  logic       clear;
  logic [3:0] value;
  logic       expired;
  logic       busy;
  logic [3:0] remaining;
  logic       one_hz;

  interval_timer #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .Reset_n    (rst_n),
    .start_timer(start_timer),
    .clear      (clear),
    .value      (value),
    .expired    (expired),
    .busy       (busy),
    .remaining  (remaining),
    .one_hz     (one_hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   exp_seen = 0;
  int   hz_seen = 0;
  out_t exp_q[$];

  // Reference model: idle / loading / counting, with the countdown derived from elapsed edges.
  localparam int M_IDLE = 0, M_LOAD = 1, M_COUNT = 2;
  int m_phase = M_IDLE;
  int m_t0 = 0;
  int m_v = 0;
  int m_rem = 0;
  int t_now = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic c, input logic s, input logic [3:0] v,
                            output out_t e);
    int el;
    e = '0;
    if (!r || c) begin
      m_phase = M_IDLE;
      m_rem   = 0;
    end else begin
      case (m_phase)
        M_IDLE: if (s) m_phase = M_LOAD;
        M_LOAD: if (!s) begin
          m_rem = int'(v);
          if (v == 4'd0) begin
            e.expired = 1'b1;
            m_phase   = M_IDLE;
          end else begin
            m_phase = M_COUNT;
            m_t0    = t_now;
            m_v     = int'(v);
          end
        end
        default: begin
          el = t_now - m_t0;
          if (el % CLK_DIV == 0) begin
            e.one_hz = 1'b1;
            m_rem    = m_v - el / CLK_DIV;
            if (m_rem == 0) begin
              e.expired = 1'b1;
              m_phase   = M_IDLE;
            end
          end
          if (s) m_phase = M_LOAD;
        end
      endcase
    end
    e.busy      = (m_phase != M_IDLE);
    e.remaining = m_rem[3:0];
  endtask

  task automatic drive(input logic r, input logic c, input logic s, input logic [3:0] v);
    out_t e;
    rst_n       = r;
    clear       = c;
    start_timer = s;
    value       = v;
    model_step(r, c, s, v, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    t_now++;
  endtask

  task automatic idle_for(input int n, input logic [3:0] v);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, v);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    #1;
    exp_seen = 0;
    hz_seen  = 0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Monitor: compares every registered output set against the queued expectation.
  initial begin
    out_t e;
    out_t got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = '{expired, busy, remaining, one_hz};
        check("outputs", 32'(got), 32'(e));
        if (expired === 1'b1) exp_seen++;
        if (one_hz === 1'b1) hz_seen++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; start_timer = 1'b0; value = 4'd0;

    // value=6: six seconds, six one_hz pulses, one expiry.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 4'd6);
    idle_for(30, 4'd6);
    settle();
    check("v6_expired_count", 32'(exp_seen), 32'd1);
    check("v6_one_hz_count", 32'(hz_seen), 32'd6);

    // value=0: immediate expiry after LOAD, no ticks.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 4'd0);
    idle_for(8, 4'd0);
    settle();
    check("v0_expired_count", 32'(exp_seen), 32'd1);
    check("v0_one_hz_count", 32'(hz_seen), 32'd0);

    // Retrigger at edge 6 with value=2 discards the first interval.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 4'd3);
    idle_for(5, 4'd3);
    drive(1'b1, 1'b0, 1'b1, 4'd2);
    idle_for(14, 4'd2);
    settle();
    check("retrig_expired_count", 32'(exp_seen), 32'd1);
    check("retrig_one_hz_count", 32'(hz_seen), 32'd3);

    // Clear together with start at edge 6 aborts silently.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 4'd3);
    idle_for(5, 4'd3);
    drive(1'b1, 1'b1, 1'b1, 4'd3);
    idle_for(20, 4'd3);
    settle();
    check("clear_expired_count", 32'(exp_seen), 32'd0);

    // Reset mid-count, then a fresh 2-second interval.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 4'd2);
    idle_for(4, 4'd2);
    drive(1'b0, 1'b0, 1'b0, 4'd2);
    settle();
    check("reset_abort_expired_count", 32'(exp_seen), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 4'd2);
    idle_for(12, 4'd2);
    settle();
    check("reset_fresh_expired_count", 32'(exp_seen), 32'd1);

    // value=1 with start exactly at the expiry edge: two expiries.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 4'd1);
    idle_for(4, 4'd1);
    drive(1'b1, 1'b0, 1'b1, 4'd1);
    idle_for(8, 4'd1);
    settle();
    check("expiry_restart_expired_count", 32'(exp_seen), 32'd2);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic       r, c, s;
      logic [3:0] v;
      r = ($urandom_range(0, 63) != 0);
      c = ($urandom_range(0, 31) == 0);
      s = ($urandom_range(0, 15) == 0);
      v = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      drive(r, c, s, v);
    end
    settle();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
